// File: rtl/snake_pixel_engine.sv
// ---------------------------------------------------------------------------
// snake_pixel_engine
//
// Game-state and pixel-colour stage that feeds the VGA controller. It keeps
// the snake as a shift register of grid cells and advances it one cell on
// each move tick. It applies the direction buttons and the wall and
// self-collision rules. It also answers the controller's per-pixel coordinate
// query with a colour word, two cycles after the query.
//
// Ports
//   iCLK          pixel clock, the only clock
//   iRST          synchronous active-high reset
//   iStep         one-cycle move tick
//   iGrow         one-cycle request to lengthen by one at the next step
//   iUpButton     level button, asynchronous to iCLK
//   iDownButton   level button, asynchronous to iCLK
//   iLeftButton   level button, asynchronous to iCLK
//   iRightButton  level button, asynchronous to iCLK
//   iCoord_X      active-area pixel X being drawn
//   iCoord_Y      active-area pixel Y being drawn
//   oRed/oGreen/oBlue  colour for the queried pixel, two cycles later
//   oLength       current segment count
//   oDead         high once the snake has collided
// ---------------------------------------------------------------------------
module snake_pixel_engine #(
    parameter int CELL_LOG2 = 3,
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60,
    parameter int MAX_LEN   = 32,
    parameter int START_LEN = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iStep,
    input  logic       iGrow,
    input  logic       iUpButton,
    input  logic       iDownButton,
    input  logic       iLeftButton,
    input  logic       iRightButton,
    input  logic [9:0] iCoord_X,
    input  logic [9:0] iCoord_Y,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue,
    output logic [5:0] oLength,
    output logic       oDead
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    // A direction and its opposite differ only in bit 0. The reversal check
    // depends on this encoding.
    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [6:0] WALL_X    = 7'(GRID_W - 1);
    localparam logic [5:0] WALL_Y    = 6'(GRID_H - 1);
    localparam logic [5:0] START_Y   = 6'(GRID_H / 2);
    localparam logic [5:0] LEN_MAX   = 6'(MAX_LEN);
    localparam logic [5:0] LEN_START = 6'(START_LEN);

    logic [1:0] state;
    logic [1:0] dir;
    logic [1:0] pendDir;
    logic       growPend;
    logic [5:0] len;
    logic [6:0] segX [MAX_LEN];
    logic [5:0] segY [MAX_LEN];

    logic [3:0] btnMeta;
    logic [3:0] btnSync;
    logic       reqValid;
    logic [1:0] reqDir;

    logic [6:0] nextX;
    logic [5:0] nextY;
    logic       growing;
    logic       selfHit;
    logic       wallHit;
    logic       collide;
    logic       doStep;

    logic       s1Live;
    logic [9:0] s1X;
    logic [9:0] s1Y;
    logic       headHit;
    logic       bodyHit;
    logic       inGrid;
    logic       wallCell;

    // Reset body layout: a horizontal line heading right from the grid
    // centre. X is clamped at 1 so unused segments never sit in the wall.
    function automatic logic [6:0] startX(input int idx);
        int v;
        v = GRID_W / 2 - idx;
        if (v < 1) begin
            v = 1;
        end
        return 7'(v);
    endfunction

    // Two-flop synchroniser for the four button levels, packed as
    // {up, down, left, right}.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            btnMeta <= 4'b0;
            btnSync <= 4'b0;
        end else begin
            btnMeta <= {iUpButton, iDownButton, iLeftButton, iRightButton};
            btnSync <= btnMeta;
        end
    end

    // Reduce the synchronised buttons to one request, Up first and Right last.
    always_comb begin
        reqValid = 1'b1;
        reqDir   = DIR_RIGHT;
        if (btnSync[3]) begin
            reqDir = DIR_UP;
        end else if (btnSync[2]) begin
            reqDir = DIR_DOWN;
        end else if (btnSync[1]) begin
            reqDir = DIR_LEFT;
        end else if (btnSync[0]) begin
            reqDir = DIR_RIGHT;
        end else begin
            reqValid = 1'b0;
        end
    end

    // Candidate head for the next step. It uses the pending direction
    // registered before this edge, so a button update in the same cycle
    // waits for the following step.
    always_comb begin
        nextX = segX[0];
        nextY = segY[0];
        case (pendDir)
            DIR_RIGHT: nextX = segX[0] + 7'd1;
            DIR_LEFT:  nextX = segX[0] - 7'd1;
            DIR_UP:    nextY = segY[0] - 6'd1;
            default:   nextY = segY[0] + 6'd1;
        endcase
    end

    // Collision check for the candidate head. The last live segment is only
    // an obstacle when the snake grows this step; otherwise the tail moves
    // out of the way in the same step.
    always_comb begin
        growing = growPend && (len < LEN_MAX);
        selfHit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < int'(len)) && ((i != int'(len) - 1) || growing) &&
                (segX[i] == nextX) && (segY[i] == nextY)) begin
                selfHit = 1'b1;
            end
        end
        wallHit = (nextX == 7'd0) || (nextX == WALL_X) ||
                  (nextY == 6'd0) || (nextY == WALL_Y);
        collide = wallHit || selfHit;
        doStep  = (state == ST_RUN) && iStep;
    end

    // Game state: IDLE/RUN/DEAD, direction registers, grow flag and the
    // segment shift register. A collision freezes the body, the length and
    // the direction. A fresh iGrow takes priority over the clear done by a
    // step in the same cycle.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= ST_IDLE;
            dir      <= DIR_RIGHT;
            pendDir  <= DIR_RIGHT;
            growPend <= 1'b0;
            len      <= LEN_START;
            for (int i = 0; i < MAX_LEN; i++) begin
                segX[i] <= startX(i);
                segY[i] <= START_Y;
            end
        end else begin
            if ((state == ST_IDLE) && reqValid) begin
                state <= ST_RUN;
            end
            if (reqValid && (reqDir != (dir ^ 2'b01))) begin
                pendDir <= reqDir;
            end
            if (doStep) begin
                if (collide) begin
                    state <= ST_DEAD;
                end else begin
                    dir     <= pendDir;
                    segX[0] <= nextX;
                    segY[0] <= nextY;
                    for (int i = 1; i < MAX_LEN; i++) begin
                        segX[i] <= segX[i-1];
                        segY[i] <= segY[i-1];
                    end
                    if (growing) begin
                        len <= len + 6'd1;
                    end
                end
            end
            if (iGrow) begin
                growPend <= 1'b1;
            end else if (doStep && !collide) begin
                growPend <= 1'b0;
            end
        end
    end

    // Pixel stage 1: register the cell coordinates of the query. s1Live
    // blanks the first output after reset, so the reset-cleared coordinates
    // are never drawn as a wall cell.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1Live <= 1'b0;
            s1X    <= 10'd0;
            s1Y    <= 10'd0;
        end else begin
            s1Live <= 1'b1;
            s1X    <= iCoord_X >> CELL_LOG2;
            s1Y    <= iCoord_Y >> CELL_LOG2;
        end
    end

    // Compare the registered cell against every live segment in parallel.
    always_comb begin
        headHit = (s1X == {3'b0, segX[0]}) && (s1Y == {4'b0, segY[0]});
        bodyHit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < int'(len)) && (s1X == {3'b0, segX[i]}) &&
                (s1Y == {4'b0, segY[i]})) begin
                bodyHit = 1'b1;
            end
        end
        inGrid   = (s1X < 10'(GRID_W)) && (s1Y < 10'(GRID_H));
        wallCell = (s1X == 10'd0) || (s1X == 10'(GRID_W - 1)) ||
                   (s1Y == 10'd0) || (s1Y == 10'(GRID_H - 1));
    end

    // Pixel stage 2: register the colour. The checks run in this order:
    // outside the grid, head, body, wall, background.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oRed   <= 10'h000;
            oGreen <= 10'h000;
            oBlue  <= 10'h000;
        end else if (!s1Live || !inGrid) begin
            oRed   <= 10'h000;
            oGreen <= 10'h000;
            oBlue  <= 10'h000;
        end else if (headHit) begin
            oRed   <= 10'h3FF;
            oGreen <= 10'h3FF;
            oBlue  <= 10'h000;
        end else if (bodyHit) begin
            oRed   <= (state == ST_DEAD) ? 10'h3FF : 10'h000;
            oGreen <= (state == ST_DEAD) ? 10'h000 : 10'h3FF;
            oBlue  <= 10'h000;
        end else if (wallCell) begin
            oRed   <= 10'h000;
            oGreen <= 10'h000;
            oBlue  <= 10'h3FF;
        end else begin
            oRed   <= 10'h000;
            oGreen <= 10'h000;
            oBlue  <= 10'h000;
        end
    end

    assign oLength = len;
    assign oDead   = (state == ST_DEAD);

endmodule
